// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer for the ALU shift path.
// A small per-cycle shifter moves the accumulator by at most STEP bit
// positions per clock. The control FSM repeats that step until the latched
// amount is used up, then pulses done. The result stays in the accumulator
// until the next accepted start.
module shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] shifts,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   // Operation encodings. Any code above OP_ROL is a pass-through.
   localparam logic [2:0] OP_SHR  = 3'b000;
   localparam logic [2:0] OP_SHRA = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;

   localparam logic [AMT_W:0] STEP_MAX = (AMT_W+1)'(STEP);
   localparam logic [AMT_W:0] WIDTH_K  = (AMT_W+1)'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] acc_q, acc_step;
   logic [AMT_W-1:0] rem_q, rem_next;
   logic [2:0]       op_q;
   logic             sign_q;
   logic             accept;
   logic             skip_shift;
   logic [AMT_W-1:0] n_amt;
   logic [AMT_W-1:0] step_k;
   logic [AMT_W:0]   step_inv;
   logic             unused_shift_bits;

   // Only the low AMT_W bits of the amount take part, so n is taken mod WIDTH.
   assign n_amt             = shifts[AMT_W-1:0];
   assign unused_shift_bits = ^shifts[WIDTH-1:AMT_W];

   // A zero amount or a pass-through op needs no shift cycles.
   assign skip_shift = (n_amt == '0) || (op > OP_ROL);

   // Per-cycle step size: the remaining count, capped at STEP.
   always_comb begin
      // NOTE: every signal gets a default before any branch. A path that does
      // not assign a signal in combinational logic would otherwise infer a latch.
      step_k   = rem_q;
      step_inv = WIDTH_K - {1'b0, rem_q};
      if ({1'b0, rem_q} > STEP_MAX) begin
         step_k   = STEP_MAX[AMT_W-1:0];
         step_inv = WIDTH_K - STEP_MAX;
      end
      rem_next = rem_q - step_k;
   end

   // Small shifter: applies one step of the latched operation to the accumulator.
   always_comb begin
      acc_step = acc_q;
      case (op_q)
         OP_SHR:  acc_step = acc_q >> step_k;
         OP_SHRA: acc_step = (acc_q >> step_k)
                           | (sign_q ? ~({WIDTH{1'b1}} >> step_k) : '0);
         OP_SHL:  acc_step = acc_q << step_k;
         OP_ROR:  acc_step = (acc_q >> step_k) | (acc_q << step_inv);
         OP_ROL:  acc_step = (acc_q << step_k) | (acc_q >> step_inv);
         default: acc_step = acc_q;
      endcase
   end

   // State register with synchronous clear.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments. All flops then sample
      // pre-edge values, and simulation order cannot change the behaviour.
      if (clr) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state logic. A start is accepted only in IDLE or DONE.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = skip_shift ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (rem_next == '0) state_next = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = skip_shift ? S_DONE : S_SHIFT;
            end else begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath: load operands on accept, step while shifting, hold otherwise.
   always_ff @(posedge clk) begin
      if (clr) begin
         acc_q  <= '0;
         rem_q  <= '0;
         op_q   <= '0;
         sign_q <= 1'b0;
      end else if (accept) begin
         acc_q  <= in1;
         rem_q  <= n_amt;
         op_q   <= op;
         sign_q <= in1[WIDTH-1];
      end else if (state == S_SHIFT) begin
         acc_q  <= acc_step;
         rem_q  <= rem_next;
      end
   end

   assign busy   = (state == S_SHIFT);
   assign done   = (state == S_DONE);
   assign result = acc_q;

endmodule
